sq_register: RTL and testbench

SQ_REGISTER -- requirements
Module: sq_register

---
 rtl/sq_register.sv | 147 ++++++++++++++
 tb/tb_sq_register.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sq_register.sv
// Sequence register: captures the order code from the write bus and holds the EXTEND, next-instruction,
// inhibit and interrupt status bits. Optional macro SQ_RUPT_EN enables interrupt pending/entry logic.
module sq_register (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       vcc,
    input  logic       gnd,
    input  logic       gojam,
    input  logic       nisq,
    input  logic       t02,
    input  logic       t12_n,
    input  logic       phs2_n,
    input  logic       wt_n,
    input  logic       rt_n,
    input  logic       ct_n,
    input  logic       wl16_n,
    input  logic       wl14_n,
    input  logic       wl13_n,
    input  logic       wl12_n,
    input  logic       wl11_n,
    input  logic       wl10_n,
    input  logic       ext,
    input  logic       extpls,
    input  logic       inkl,
    input  logic       inkbt1,
    input  logic       relpls,
    input  logic       inhlpls,
    input  logic       ovnhrp,
    input  logic       n5xp4,
    input  logic       mnhrpt,
    input  logic       ruptor_n,
    input  logic       krpt,
    input  logic       mtcsai,
    output logic [2:0] sq,
    output logic [1:0] qc,
    output logic       sqr10,
    output logic       sqext,
    output logic       futext,
    output logic       nisql,
    output logic       inhint,
    output logic       rptpend,
    output logic       iip
);

    localparam int unsigned SQ_W = 3;
    localparam int unsigned QC_W = 2;

    logic [SQ_W-1:0] r_sq;
    logic [QC_W-1:0] r_qc;
    logic            r_sqr10;
    logic            r_sqext;
    logic            r_futext;
    logic            r_nisql;
    logic            r_inhint;
    logic            w_ld;
    logic            w_rupt;
    logic            w_unused;

    assign w_ld = r_nisql & ~t12_n & ~wt_n & ~inkl;

`ifdef SQ_RUPT_EN
    logic r_rptpend;
    logic r_iip;

    assign w_rupt = w_ld & r_rptpend & ~r_inhint & ~r_iip & ~ovnhrp & ~n5xp4
                  & ~mnhrpt & ~inkbt1 & ~r_futext;

    // Pending request and interrupt-in-progress; a taken entry retires the pending request.
    always_ff @(posedge clock) begin
        if (!rst_n || gojam) begin
            r_rptpend <= 1'b0;
            r_iip     <= 1'b0;
        end else begin
            if (krpt)
                r_rptpend <= 1'b0;
            else if (!ruptor_n)
                r_rptpend <= 1'b1;
            else if (w_rupt)
                r_rptpend <= 1'b0;

            if (w_rupt)
                r_iip <= 1'b1;
            else if (relpls)
                r_iip <= 1'b0;
        end
    end

    assign rptpend  = r_rptpend;
    assign iip      = r_iip;
    assign w_unused = ^{vcc, gnd, t02, phs2_n, rt_n, ct_n};
`else
    assign w_rupt   = 1'b0;
    assign rptpend  = 1'b0;
    assign iip      = 1'b0;
    assign w_unused = ^{vcc, gnd, t02, phs2_n, rt_n, ct_n, ruptor_n, krpt,
                        inkbt1, ovnhrp, n5xp4, mnhrpt};
`endif

    // Order-code load and status flags; set requests beat same-cycle clears.
    always_ff @(posedge clock) begin
        if (!rst_n || gojam) begin
            r_sq     <= '0;
            r_qc     <= '0;
            r_sqr10  <= 1'b0;
            r_sqext  <= 1'b0;
            r_futext <= 1'b0;
            r_nisql  <= 1'b0;
            r_inhint <= 1'b0;
        end else begin
            if (w_rupt) begin
                r_sq    <= '0;
                r_qc    <= '0;
                r_sqr10 <= 1'b0;
                r_sqext <= 1'b0;
            end else if (w_ld) begin
                r_sq    <= {~wl16_n, ~wl14_n, ~wl13_n};
                r_qc    <= {~wl12_n, ~wl11_n};
                r_sqr10 <= ~wl10_n;
                r_sqext <= r_futext;
            end

            if (ext || extpls)
                r_futext <= 1'b1;
            else if (w_ld)
                r_futext <= 1'b0;

            if (nisq)
                r_nisql <= 1'b1;
            else if (w_ld)
                r_nisql <= 1'b0;

            if (inhlpls || mtcsai)
                r_inhint <= 1'b1;
            else if (relpls)
                r_inhint <= 1'b0;
        end
    end

    assign sq     = r_sq;
    assign qc     = r_qc;
    assign sqr10  = r_sqr10;
    assign sqext  = r_sqext;
    assign futext = r_futext;
    assign nisql  = r_nisql;
    assign inhint = r_inhint;

endmodule

// File: tb/tb_sq_register.sv
// Scoreboard bench for sq_register: stimulus queues expected register snapshots, a negedge monitor checks them.
module tb_sq_register;

    logic clock = 1'b0;
    logic rst_n = 1'b0, vcc = 1'b1, gnd = 1'b0, gojam = 1'b0, nisq = 1'b0;
    logic t02 = 1'b0, t12_n = 1'b1, phs2_n = 1'b1, wt_n = 1'b1, rt_n = 1'b1, ct_n = 1'b1;
    logic wl16_n = 1'b1, wl14_n = 1'b1, wl13_n = 1'b1, wl12_n = 1'b1, wl11_n = 1'b1, wl10_n = 1'b1;
    logic ext = 1'b0, extpls = 1'b0, inkl = 1'b0, inkbt1 = 1'b0, relpls = 1'b0, inhlpls = 1'b0;
    logic ovnhrp = 1'b0, n5xp4 = 1'b0, mnhrpt = 1'b0, ruptor_n = 1'b1, krpt = 1'b0, mtcsai = 1'b0;
    logic [2:0] sq;
    logic [1:0] qc;
    logic sqr10, sqext, futext, nisql, inhint, rptpend, iip;

    sq_register dut (
        .clock(clock), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .gojam(gojam), .nisq(nisq),
        .t02(t02), .t12_n(t12_n), .phs2_n(phs2_n), .wt_n(wt_n), .rt_n(rt_n), .ct_n(ct_n),
        .wl16_n(wl16_n), .wl14_n(wl14_n), .wl13_n(wl13_n), .wl12_n(wl12_n), .wl11_n(wl11_n),
        .wl10_n(wl10_n), .ext(ext), .extpls(extpls), .inkl(inkl), .inkbt1(inkbt1),
        .relpls(relpls), .inhlpls(inhlpls), .ovnhrp(ovnhrp), .n5xp4(n5xp4), .mnhrpt(mnhrpt),
        .ruptor_n(ruptor_n), .krpt(krpt), .mtcsai(mtcsai),
        .sq(sq), .qc(qc), .sqr10(sqr10), .sqext(sqext), .futext(futext), .nisql(nisql),
        .inhint(inhint), .rptpend(rptpend), .iip(iip)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] obs;

    assign obs = {sq, qc, sqr10, sqext, futext, nisql, inhint, rptpend, iip};

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Vector layout: {sq[2:0], qc[1:0], sqr10, sqext, futext, nisql, inhint, rptpend, iip}
    function automatic logic [11:0] mk(input logic [2:0] s, input logic [1:0] q, input logic r10,
                                       input logic se, input logic fe, input logic nl,
                                       input logic ih, input logic rp, input logic ii);
        return {s, q, r10, se, fe, nl, ih, rp, ii};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [11:0] v);
        exp_t e;
        e.cyc  = edge_cnt;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic strobes(input logic on);
        t12_n = ~on;
        wt_n  = ~on;
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != edge_cnt || obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b (edge %0d, due %0d)",
                         e.name, obs, e.v, edge_cnt, e.cyc);
            end
        end
    end

    initial begin
        // reset held for two edges
        cyc(); expect_now("reset_1", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); expect_now("reset_2", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        n_cmp++;
        if (obs !== 12'd0) begin
            n_bad++;
            $display("FAIL direct reset: got %b", obs);
        end
        rst_n = 1'b1;

        // basic load of wl13
        wl13_n = 1'b0; nisq = 1'b1;
        cyc(); expect_now("nisq_set", mk(3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0));
        nisq = 1'b0; strobes(1);
        cyc(); expect_now("load_001", mk(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        n_cmp++;
        if (sq !== 3'b001 || qc !== 2'b00 || sqr10 !== 1'b0 || nisql !== 1'b0) begin
            n_bad++;
            $display("FAIL direct load_001: sq=%b qc=%b sqr10=%b nisql=%b", sq, qc, sqr10, nisql);
        end
        strobes(0); wl13_n = 1'b1;
        cyc(); expect_now("hold_001", mk(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        // extend then load captures sqext
        ext = 1'b1; wl14_n = 1'b0; wl13_n = 1'b0;
        cyc(); expect_now("ext_set", mk(3'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0));
        ext = 1'b0; nisq = 1'b1;
        cyc(); expect_now("nisq_ext", mk(3'd1, 2'd0, 0, 0, 1, 1, 0, 0, 0));
        nisq = 1'b0; strobes(1);
        cyc(); expect_now("load_011_ext", mk(3'd3, 2'd0, 0, 1, 0, 0, 0, 0, 0));
        n_cmp++;
        if (sq !== 3'b011 || sqext !== 1'b1) begin
            n_bad++;
            $display("FAIL direct load_011_ext: sq=%b sqext=%b", sq, sqext);
        end
        strobes(0); nisq = 1'b1;
        cyc(); expect_now("nisq_2", mk(3'd3, 2'd0, 0, 1, 0, 1, 0, 0, 0));
        nisq = 1'b0; wl14_n = 1'b1; wl13_n = 1'b1;
        wl16_n = 1'b0; wl12_n = 1'b0; wl10_n = 1'b0; strobes(1);
        cyc(); expect_now("load_100_noext", mk(3'd4, 2'd2, 1, 0, 0, 0, 0, 0, 0));

        // ext coinciding with load: futext set wins, sqext takes old futext
        strobes(0); wl16_n = 1'b1; wl12_n = 1'b1; wl10_n = 1'b1; nisq = 1'b1;
        cyc(); expect_now("nisq_3", mk(3'd4, 2'd2, 1, 0, 0, 1, 0, 0, 0));
        nisq = 1'b0; strobes(1); ext = 1'b1;
        cyc(); expect_now("load_ext_same", mk(3'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0));

        // inkl defers the load
        ext = 1'b0; strobes(0); nisq = 1'b1;
        cyc(); expect_now("nisq_4", mk(3'd0, 2'd0, 0, 0, 1, 1, 0, 0, 0));
        nisq = 1'b0; inkl = 1'b1; strobes(1); wl11_n = 1'b0;
        cyc(); expect_now("inkl_defer", mk(3'd0, 2'd0, 0, 0, 1, 1, 0, 0, 0));
        n_cmp++;
        if (nisql !== 1'b1 || qc !== 2'b00) begin
            n_bad++;
            $display("FAIL direct inkl_defer: nisql=%b qc=%b", nisql, qc);
        end
        inkl = 1'b0;
        cyc(); expect_now("inkl_release", mk(3'd0, 2'd1, 0, 1, 0, 0, 0, 0, 0));
        strobes(0); wl11_n = 1'b1;
        cyc(); expect_now("hold_qc1", mk(3'd0, 2'd1, 0, 1, 0, 0, 0, 0, 0));

        // inhint set/clear priority
        inhlpls = 1'b1;
        cyc(); expect_now("inhint_set", mk(3'd0, 2'd1, 0, 1, 0, 0, 1, 0, 0));
        inhlpls = 1'b0; relpls = 1'b1; mtcsai = 1'b1;
        cyc(); expect_now("inhint_set_wins", mk(3'd0, 2'd1, 0, 1, 0, 0, 1, 0, 0));
        mtcsai = 1'b0;
        cyc(); expect_now("inhint_clr", mk(3'd0, 2'd1, 0, 1, 0, 0, 0, 0, 0));
        relpls = 1'b0;

        // gojam clears everything, overriding a same-cycle ext
        ext = 1'b1; nisq = 1'b1;
        cyc(); expect_now("pre_gojam", mk(3'd0, 2'd1, 0, 1, 1, 1, 0, 0, 0));
        nisq = 1'b0; gojam = 1'b1;
        cyc(); expect_now("gojam", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        n_cmp++;
        if (obs !== 12'd0) begin
            n_bad++;
            $display("FAIL direct gojam: got %b", obs);
        end
        gojam = 1'b0; ext = 1'b0;
        cyc(); expect_now("post_gojam", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

`ifdef SQ_RUPT_EN
        ruptor_n = 1'b0;
        cyc(); expect_now("rpt_set", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
        krpt = 1'b1;
        cyc(); expect_now("krpt_wins", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        krpt = 1'b0;
        cyc(); expect_now("rpt_reset", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
        ruptor_n = 1'b1; nisq = 1'b1;
        cyc(); expect_now("rpt_nisq", mk(3'd0, 2'd0, 0, 0, 0, 1, 0, 1, 0));
        nisq = 1'b0; strobes(1); wl13_n = 1'b0;
        cyc(); expect_now("rupt_entry", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
        strobes(0); wl13_n = 1'b1; relpls = 1'b1;
        cyc(); expect_now("iip_clr", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        relpls = 1'b0; ruptor_n = 1'b0;
        cyc(); expect_now("rpt_set_2", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
        ruptor_n = 1'b1; inhlpls = 1'b1;
        cyc(); expect_now("inhibit", mk(3'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
        inhlpls = 1'b0; nisq = 1'b1;
        cyc(); expect_now("nisq_inh", mk(3'd0, 2'd0, 0, 0, 0, 1, 1, 1, 0));
        nisq = 1'b0; strobes(1); wl13_n = 1'b0;
        cyc(); expect_now("inhibited_load", mk(3'd1, 2'd0, 0, 0, 0, 0, 1, 1, 0));
        strobes(0); wl13_n = 1'b1;
`else
        ruptor_n = 1'b0;
        cyc(); expect_now("rpt_ignored", mk(3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        ruptor_n = 1'b1; nisq = 1'b1;
        cyc(); expect_now("nisq_norupt", mk(3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0));
        nisq = 1'b0; strobes(1); wl13_n = 1'b0;
        cyc(); expect_now("load_norupt", mk(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        strobes(0); wl13_n = 1'b1;
`endif

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) cyc();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, expected %b", e.name, e.v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
